// File: rtl/coax_bus_initiator.sv
// rtl/coax_bus_initiator.sv - host-side initiator for the coax transceiver 10-bit shared data bus
// Optional read timeout enabled by defining COAX_BUS_TIMEOUT_EN.
module coax_bus_initiator #(
    parameter int STROBE_CYCLES  = 4,
    parameter int SETTLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [9:0] cmd_data,
    output logic       rsp_valid,
    output logic [9:0] rsp_data,
    output logic       rsp_error,
    output logic       rsp_timeout,
    output logic       bus_tx_load,
    input  logic       bus_tx_full,
    output logic       bus_rx_enable,
    input  logic       bus_rx_data_available,
    input  logic       bus_rx_error,
    output logic       bus_rx_read,
    output logic [9:0] bus_data_out,
    output logic       bus_data_oe,
    input  logic [9:0] bus_data_in
);

    localparam int STROBE_W = $clog2(STROBE_CYCLES + 3);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 3);
    localparam int CW       = (STROBE_W > SETTLE_W) ? STROBE_W : SETTLE_W;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        W_WAIT,
        W_SETUP,
        W_STROBE,
        W_HOLD,
        R_EN,
        R_WAIT,
        R_SETTLE,
        R_STROBE,
        R_DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            ready_q;
    logic            rsp_valid_q;
    logic [9:0]      rsp_data_q;
    logic            rsp_error_q;
    logic            tx_load_q;
    logic            rx_en_q;
    logic            rx_read_q;
    logic [9:0]      data_out_q;
    logic            oe_q;
    logic [2:0]      sync1_q;
    logic [2:0]      sync2_q;
    logic            tx_full_s;
    logic            rx_da_s;
    logic            rx_err_s;
    logic            capture;

    // Far-end flags are asynchronous to clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus_tx_full, bus_rx_data_available, bus_rx_error};
            sync2_q <= sync1_q;
        end
    end

    assign tx_full_s = sync2_q[2];
    assign rx_da_s   = sync2_q[1];
    assign rx_err_s  = sync2_q[0];

    // Data is sampled on the edge entering the last settle cycle so rsp_valid lands in it.
    assign capture = ((state_q == R_WAIT) && rx_da_s && (SETTLE_CYCLES == 1)) ||
                     ((state_q == R_SETTLE) && (cnt_q == CW'(1)));

`ifdef COAX_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 3);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q;
    logic          rsp_timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            tx_load_q   <= 1'b0;
            rx_en_q     <= 1'b0;
            rx_read_q   <= 1'b0;
            data_out_q  <= '0;
            oe_q        <= 1'b0;
`ifdef COAX_BUS_TIMEOUT_EN
            tmo_q         <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= capture;
            if (capture) begin
                rsp_data_q  <= bus_data_in;
                rsp_error_q <= rx_err_s;
            end
`ifdef COAX_BUS_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (cmd_valid && ready_q) begin
                        ready_q <= 1'b0;
                        if (cmd_write) begin
                            state_q    <= W_WAIT;
                            data_out_q <= cmd_data;
                            oe_q       <= 1'b1;
                        end else begin
                            state_q <= R_EN;
                            rx_en_q <= 1'b1;
                            cnt_q   <= SETTLE_LAST;
                        end
                    end
                end
                W_WAIT: begin
                    if (!tx_full_s) begin
                        state_q <= W_SETUP;
                        cnt_q   <= SETTLE_LAST;
                    end
                end
                W_SETUP: begin
                    if (cnt_q == '0) begin
                        state_q   <= W_STROBE;
                        tx_load_q <= 1'b1;
                        cnt_q     <= STROBE_LAST;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                W_STROBE: begin
                    if (cnt_q == '0) begin
                        state_q   <= W_HOLD;
                        tx_load_q <= 1'b0;
                        cnt_q     <= HOLD_LAST;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                W_HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        oe_q    <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                R_EN: begin
                    if (cnt_q == '0) begin
                        state_q <= R_WAIT;
`ifdef COAX_BUS_TIMEOUT_EN
                        tmo_q <= TMO_LAST;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                R_WAIT: begin
                    if (rx_da_s) begin
                        state_q <= R_SETTLE;
                        cnt_q   <= SETTLE_LAST;
                    end
`ifdef COAX_BUS_TIMEOUT_EN
                    else if (tmo_q == '0) begin
                        state_q       <= IDLE;
                        rx_en_q       <= 1'b0;
                        ready_q       <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_error_q   <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
`endif
                end
                R_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q   <= R_STROBE;
                        rx_read_q <= 1'b1;
                        cnt_q     <= STROBE_LAST;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                R_STROBE: begin
                    if (cnt_q == '0) begin
                        state_q   <= R_DONE;
                        rx_read_q <= 1'b0;
`ifdef COAX_BUS_TIMEOUT_EN
                        tmo_q <= TMO_LAST;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                R_DONE: begin
                    if (!rx_da_s) begin
                        state_q <= IDLE;
                        rx_en_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
`ifdef COAX_BUS_TIMEOUT_EN
                    else if (tmo_q == '0) begin
                        state_q       <= IDLE;
                        rx_en_q       <= 1'b0;
                        ready_q       <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_error_q   <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = ready_q & ~reset;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_error     = rsp_error_q;
    assign bus_tx_load   = tx_load_q;
    assign bus_rx_enable = rx_en_q;
    assign bus_rx_read   = rx_read_q;
    assign bus_data_out  = data_out_q;
    assign bus_data_oe   = oe_q;
`ifdef COAX_BUS_TIMEOUT_EN
    assign rsp_timeout   = rsp_timeout_q;
`else
    assign rsp_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_coax_bus_initiator.sv
// tb/tb_coax_bus_initiator.sv - scoreboard bench for coax_bus_initiator
module tb_coax_bus_initiator;

    localparam int STROBE  = 4;
    localparam int SETTLE  = 3;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [9:0] cmd_data;
    logic       rsp_valid;
    logic [9:0] rsp_data;
    logic       rsp_error;
    logic       rsp_timeout;
    logic       bus_tx_load;
    logic       bus_tx_full;
    logic       bus_rx_enable;
    logic       bus_rx_data_available;
    logic       bus_rx_error;
    logic       bus_rx_read;
    logic [9:0] bus_data_out;
    logic       bus_data_oe;
    logic [9:0] bus_data_in;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] data;
        logic       err;
        logic       tmo;
    } rsp_t;

    rsp_t exp_q[$];

    coax_bus_initiator #(
        .STROBE_CYCLES (STROBE),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_write            (cmd_write),
        .cmd_data             (cmd_data),
        .rsp_valid            (rsp_valid),
        .rsp_data             (rsp_data),
        .rsp_error            (rsp_error),
        .rsp_timeout          (rsp_timeout),
        .bus_tx_load          (bus_tx_load),
        .bus_tx_full          (bus_tx_full),
        .bus_rx_enable        (bus_rx_enable),
        .bus_rx_data_available(bus_rx_data_available),
        .bus_rx_error         (bus_rx_error),
        .bus_rx_read          (bus_rx_read),
        .bus_data_out         (bus_data_out),
        .bus_data_oe          (bus_data_oe),
        .bus_data_in          (bus_data_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin
            tick;
            n++;
        end
        check("ready_wait", 16'(cmd_ready), 16'(1));
    endtask

    // Returns in cycle 1 (first cycle after the acceptance edge).
    task automatic issue(input logic w, input logic [9:0] d);
        wait_ready;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_data  = d;
        tick;
        cmd_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        rsp_t e;
        #1;
        if (!reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 16'(rsp_data), 16'h0dea);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", 16'(rsp_data), 16'(e.data));
                check("rsp_error", 16'(rsp_error), 16'(e.err));
                check("rsp_timeout", 16'(rsp_timeout), 16'(e.tmo));
            end
        end
    end

    logic prev_oe = 1'b0;
    logic prev_rx = 1'b0;
    always @(negedge clk) begin
        if (!reset && (bus_data_oe || bus_rx_enable))
            check("turnaround", 16'({bus_data_oe && bus_rx_enable,
                                     (bus_rx_enable && prev_oe) || (bus_data_oe && prev_rx)}), 16'(0));
        prev_oe = bus_data_oe;
        prev_rx = bus_rx_enable;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit saw;
        reset                 = 1'b1;
        cmd_valid             = 1'b1;
        cmd_write             = 1'b1;
        cmd_data              = 10'h3FF;
        bus_tx_full           = 1'b0;
        bus_rx_data_available = 1'b0;
        bus_rx_error          = 1'b0;
        bus_data_in           = 10'h000;
        repeat (3) tick;
        check("rst_ready", 16'(cmd_ready), 16'(0));
        check("rst_oe", 16'(bus_data_oe), 16'(0));
        check("rst_load", 16'(bus_tx_load), 16'(0));
        check("rst_rxen", 16'(bus_rx_enable), 16'(0));
        check("rst_read", 16'(bus_rx_read), 16'(0));
        check("rst_rspv", 16'(rsp_valid), 16'(0));
        check("rst_dout", 16'(bus_data_out), 16'(0));
        check("rst_rspd", 16'(rsp_data), 16'(0));
        reset     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("post_rst_ready", 16'(cmd_ready), 16'(1));
        tick;
        check("rst_cmd_not_taken", 16'(bus_data_oe), 16'(0));

        // Plain write.
        issue(1'b1, 10'h2A5);
        for (int c = 1; c <= 15; c++) begin
            if (c == 1) check("wr1_dout", 16'(bus_data_out), 16'h2A5);
            check($sformatf("wr1_load@%0d", c), 16'(bus_tx_load), 16'(c >= 5 && c <= 8));
            check($sformatf("wr1_oe@%0d", c), 16'(bus_data_oe), 16'(c <= 13));
            check($sformatf("wr1_ready@%0d", c), 16'(cmd_ready), 16'(c >= 14));
            tick;
        end

        // Write held off by tx_full, released during cycle 20.
        bus_tx_full = 1'b1;
        tick;
        tick;
        issue(1'b1, 10'h155);
        for (int c = 1; c <= 35; c++) begin
            check($sformatf("wr2_load@%0d", c), 16'(bus_tx_load), 16'(c >= 26 && c <= 29));
            check($sformatf("wr2_oe@%0d", c), 16'(bus_data_oe), 16'(c <= 34));
            if (c == 20) bus_tx_full = 1'b0;
            tick;
        end

        // Read with data already available and error flagged.
        bus_rx_data_available = 1'b1;
        bus_data_in           = 10'h3C1;
        bus_rx_error          = 1'b1;
        tick;
        tick;
        exp_q.push_back('{10'h3C1, 1'b1, 1'b0});
        issue(1'b0, 10'h000);
        for (int c = 1; c <= 14; c++) begin
            check($sformatf("rd1_rxen@%0d", c), 16'(bus_rx_enable), 16'(c <= 12));
            check($sformatf("rd1_read@%0d", c), 16'(bus_rx_read), 16'(c >= 8 && c <= 11));
            check($sformatf("rd1_rspv@%0d", c), 16'(rsp_valid), 16'(c == 7));
            if (c == 10) bus_rx_data_available = 1'b0;
            tick;
        end

        // Second read, different word, no error.
        bus_rx_data_available = 1'b1;
        bus_data_in           = 10'h07E;
        bus_rx_error          = 1'b0;
        tick;
        tick;
        exp_q.push_back('{10'h07E, 1'b0, 1'b0});
        issue(1'b0, 10'h000);
        repeat (9) tick;
        bus_rx_data_available = 1'b0;
        wait_ready;

        // Write immediately followed by a read.
        bus_rx_data_available = 1'b1;
        bus_data_in           = 10'h2D2;
        exp_q.push_back('{10'h2D2, 1'b0, 1'b0});
        issue(1'b1, 10'h0F0);
        wait_ready;
        check("wr_rd_gap", 16'({bus_data_oe, bus_rx_enable}), 16'(0));
        issue(1'b0, 10'h000);
        check("wr_rd_rxen", 16'(bus_rx_enable), 16'(1));
        repeat (9) tick;
        bus_rx_data_available = 1'b0;
        wait_ready;

        // Reset during W_STROBE.
        issue(1'b1, 10'h1AB);
        repeat (5) tick;
        check("rst_mid_load_before", 16'(bus_tx_load), 16'(1));
        reset = 1'b1;
        tick;
        check("rst_mid_load", 16'(bus_tx_load), 16'(0));
        check("rst_mid_oe", 16'(bus_data_oe), 16'(0));
        check("rst_mid_rxen", 16'(bus_rx_enable), 16'(0));
        check("rst_mid_rspv", 16'(rsp_valid), 16'(0));
        check("rst_mid_ready", 16'(cmd_ready), 16'(0));
        reset = 1'b0;
        #1;
        check("rst_mid_idle", 16'(cmd_ready), 16'(1));
        saw = 1'b0;
        repeat (15) begin
            tick;
            if (bus_tx_load || bus_data_oe) saw = 1'b1;
        end
        check("rst_mid_quiet", 16'(saw), 16'(0));

        // Reset during R_SETTLE, before capture: no response may appear.
        bus_rx_data_available = 1'b1;
        bus_data_in           = 10'h111;
        tick;
        tick;
        issue(1'b0, 10'h000);
        repeat (4) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        bus_rx_data_available = 1'b0;
        saw = 1'b0;
        repeat (10) begin
            tick;
            if (rsp_valid) saw = 1'b1;
        end
        check("rd_abort_no_rsp", 16'(saw), 16'(0));

`ifdef COAX_BUS_TIMEOUT_EN
        exp_q.push_back('{10'h000, 1'b0, 1'b1});
        issue(1'b0, 10'h000);
        for (int c = 1; c <= 21; c++) begin
            check($sformatf("tmo_rspv@%0d", c), 16'(rsp_valid), 16'(c == 20));
            check($sformatf("tmo_rxen@%0d", c), 16'(bus_rx_enable), 16'(c <= 19));
            tick;
        end
`else
        issue(1'b0, 10'h000);
        saw = 1'b0;
        repeat (1000) begin
            tick;
            if (rsp_valid) saw = 1'b1;
        end
        check("no_tmo_rsp", 16'(saw), 16'(0));
        check("no_tmo_rxen", 16'(bus_rx_enable), 16'(1));
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
`endif

        check("scoreboard_empty", 16'(exp_q.size()), 16'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
